// File: rtl/matrix_storage_arbiter.sv
// Session-level round-robin arbiter that shares one matrix storage manager between
// NUM_CLIENTS requesters, steering the granted client's handshakes for a whole session.
module matrix_storage_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLIENTS-1:0]           cl_req,
    input  logic [NUM_CLIENTS-1:0]           cl_op,
    input  logic [3*NUM_CLIENTS-1:0]         cl_matrix_id,
    input  logic [8*NUM_CLIENTS-1:0]         cl_rows,
    input  logic [8*NUM_CLIENTS-1:0]         cl_cols,
    input  logic [64*NUM_CLIENTS-1:0]        cl_name,
    input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] cl_wdata,
    input  logic [NUM_CLIENTS-1:0]           cl_wvalid,
    input  logic [NUM_CLIENTS-1:0]           cl_rdata_req,
    output logic [NUM_CLIENTS-1:0]           cl_grant,
    output logic [NUM_CLIENTS-1:0]           cl_done,
    output logic [NUM_CLIENTS-1:0]           cl_rmeta_valid,
    output logic [NUM_CLIENTS-1:0]           cl_rdata_valid,
    output logic                             sm_write_req,
    output logic                             sm_read_req,
    output logic [2:0]                       sm_matrix_id,
    output logic [7:0]                       sm_write_rows,
    output logic [7:0]                       sm_write_cols,
    output logic [63:0]                      sm_write_name,
    output logic [DATA_WIDTH-1:0]            sm_write_data,
    output logic                             sm_write_data_valid,
    output logic                             sm_read_data_req,
    input  logic                             sm_write_done,
    input  logic                             sm_writer_ready,
    input  logic                             sm_read_done,
    input  logic                             sm_reader_ready,
    input  logic                             sm_read_meta_valid,
    input  logic                             sm_read_data_valid
);
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RELEASE} state_t;

    state_t                 r_state, w_next;
    logic [IW-1:0]          r_g, r_last, w_pick;
    logic                   w_found;
    logic                   r_op;
    logic [2:0]             r_id;
    logic [7:0]             r_rows, r_cols;
    logic [63:0]            r_name;
    logic [NUM_CLIENTS-1:0] r_grant, r_done;
    logic                   w_busy, w_ready, w_done_match;

    // Scan clients last+1, last+2, ... wrapping modulo NUM_CLIENTS; first requester wins.
    always_comb begin
        logic [IW:0] cand;
        w_pick  = r_last;
        w_found = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            cand = {1'b0, r_last} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_CLIENTS))
                cand = cand - (IW+1)'(NUM_CLIENTS);
            if (!w_found && cl_req[cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = cand[IW-1:0];
            end
        end
    end

    assign w_ready      = r_op ? sm_writer_ready : sm_reader_ready;
    assign w_done_match = r_op ? sm_write_done   : sm_read_done;
    assign w_busy       = (r_state == ST_BUSY);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)      w_next = ST_ISSUE;
            ST_ISSUE:   if (w_ready)      w_next = ST_BUSY;
            ST_BUSY:    if (w_done_match) w_next = ST_RELEASE;
            ST_RELEASE:                   w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g     <= '0;
            r_last  <= IW'(NUM_CLIENTS - 1);
            r_op    <= 1'b0;
            r_id    <= '0;
            r_rows  <= '0;
            r_cols  <= '0;
            r_name  <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_done <= '0;
            if (r_state == ST_IDLE && w_found) begin
                r_g     <= w_pick;
                r_op    <= cl_op[w_pick];
                r_id    <= cl_matrix_id[3*int'(w_pick) +: 3];
                r_rows  <= cl_rows[8*int'(w_pick) +: 8];
                r_cols  <= cl_cols[8*int'(w_pick) +: 8];
                r_name  <= cl_name[64*int'(w_pick) +: 64];
                r_grant <= NUM_CLIENTS'(1) << w_pick;
            end
            if (w_busy && w_done_match) begin
                r_grant <= '0;
                r_done  <= NUM_CLIENTS'(1) << r_g;
                r_last  <= r_g;
            end
        end
    end

    assign cl_grant      = r_grant;
    assign cl_done       = r_done;
    assign sm_write_req  = (r_state == ST_ISSUE) &&  r_op && sm_writer_ready;
    assign sm_read_req   = (r_state == ST_ISSUE) && !r_op && sm_reader_ready;
    assign sm_matrix_id  = r_id;
    assign sm_write_rows = r_rows;
    assign sm_write_cols = r_cols;
    assign sm_write_name = r_name;

    assign sm_write_data       = w_busy ? cl_wdata[DATA_WIDTH*int'(r_g) +: DATA_WIDTH] : '0;
    assign sm_write_data_valid = w_busy &&  r_op && cl_wvalid[r_g];
    assign sm_read_data_req    = w_busy && !r_op && cl_rdata_req[r_g];
    assign cl_rmeta_valid      = w_busy ? ({NUM_CLIENTS{sm_read_meta_valid}} & r_grant) : '0;
    assign cl_rdata_valid      = w_busy ? ({NUM_CLIENTS{sm_read_data_valid}} & r_grant) : '0;

endmodule

// File: doc/matrix_storage_arbiter.md
# matrix_storage_arbiter

Session-level arbiter that shares one `matrix_storage_manager` between `NUM_CLIENTS` requesters, e.g. UART loader, compute core and result dumper. Each client requests a complete read or write session on one matrix ID. The arbiter grants sessions one at a time in round-robin order, issues the start pulse to the storage manager, and steers that client's write-data / read-strobe signals for the whole session. It releases the grant when the storage manager reports done. The arbiter sits directly between the clients and `matrix_storage_manager`.

## Interface
Parameters:
- `NUM_CLIENTS`, 3: number of requesters (2..8)
- `DATA_WIDTH`, 32: matrix word width; must equal the storage manager's

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `cl_req`  in  NUM_CLIENTS  session request per client; level
- `cl_op`  in  NUM_CLIENTS  1 = write session, 0 = read session
- `cl_matrix_id`  in  3*NUM_CLIENTS  target matrix ID; client i uses bits [3i+2:3i]
- `cl_rows`, `cl_cols`  in  8*NUM_CLIENTS each  write dimensions
- `cl_name`  in  64*NUM_CLIENTS  write matrix name
- `cl_wdata`  in  DATA_WIDTH*NUM_CLIENTS  write data
- `cl_wvalid`  in  NUM_CLIENTS  write data valid
- `cl_rdata_req`  in  NUM_CLIENTS  request next read word
- `cl_grant`  out  NUM_CLIENTS  one-hot session owner
- `cl_done`  out  NUM_CLIENTS  one-cycle session-complete pulse
- `cl_rmeta_valid`, `cl_rdata_valid`  out  NUM_CLIENTS each  storage-manager read valids, qualified by grant
- `sm_write_req`, `sm_read_req`  out  1 each  session start pulses to the storage manager
- `sm_matrix_id`  out  3  drives both `write_matrix_id` and `read_matrix_id`
- `sm_write_rows`, `sm_write_cols`  out  8 each  write dimensions
- `sm_write_name`  out  64  write matrix name
- `sm_write_data`  out  DATA_WIDTH  write data
- `sm_write_data_valid`, `sm_read_data_req`  out  1 each  steered data handshakes
- `sm_write_done`, `sm_writer_ready`, `sm_read_done`, `sm_reader_ready`, `sm_read_meta_valid`, `sm_read_data_valid`  in  1 each  storage-manager status

Read data and metadata buses run from the storage manager to every client in parallel. The arbiter only qualifies their valids.

## Operation
States:
- **IDLE**
  - If any `cl_req` is high, pick the first requester after `last` in ascending modulo-N order.
  - Latch: index `g`, `op`, matrix ID, rows, cols, name.
  - Go to ISSUE.
- **ISSUE**
  - `cl_grant[g]` = 1.
  - Write session: when `sm_writer_ready` = 1, assert `sm_write_req` for exactly this cycle and go to BUSY. Otherwise hold.
  - Read session: same rule using `sm_reader_ready` and `sm_read_req`.
- **BUSY**
  - `cl_grant[g]` = 1.
  - `sm_write_data`/`sm_write_data_valid` are driven from `cl_wdata[g]`/`cl_wvalid[g]`, combinationally.
  - `sm_read_data_req` is driven from `cl_rdata_req[g]`, combinationally.
  - The `done` matching `op` (`sm_write_done` or `sm_read_done`) moves the FSM to RELEASE.
  - The done of the other op is ignored.
- **RELEASE**
  - `cl_grant` = 0 and `cl_done[g]` = 1 for exactly one cycle.
  - `last` <= `g`.
  - Go to IDLE.

Rules:
- Latched ID, rows, cols and name stay stable from ISSUE through RELEASE, whatever the client inputs do.
- `cl_req` of the granted client is ignored from ISSUE until RELEASE. Sessions cannot be aborted.
- A `cl_req` still high in IDLE after `cl_done` counts as a new request and competes normally.
- Outside BUSY: `sm_write_data_valid` = 0, `sm_read_data_req` = 0 and all `cl_*valid` = 0.
- `cl_rmeta_valid[i]` = `sm_read_meta_valid` & `cl_grant[i]`.
- `cl_rdata_valid[i]` = `sm_read_data_valid` & `cl_grant[i]`.
- Write `cl_op` sessions never generate read strobes, and read sessions never generate write strobes.

## Timing
- Reset (asynchronous, any state, including mid-BUSY):
  - State = IDLE, `last` = NUM_CLIENTS-1, so client 0 wins first.
  - All outputs 0; latched fields 0.
- `cl_grant`, `cl_done` and the FSM state are registered.
- `sm_*_req`, the steered data and the qualified valids are combinational from registered state and the inputs.
- Request seen in IDLE at cycle 0:
  - Grant visible at cycle 1.
  - `sm_*_req` pulse at cycle 1 at the earliest (ready already high).
  - BUSY from cycle 2.
- Done seen in BUSY at cycle d: RELEASE at d+1, IDLE at d+2. The next grant appears at d+3 at the earliest.
- Simultaneous requests: strict round-robin. A continuously requesting client waits at most NUM_CLIENTS-1 sessions.
- Done arriving in the same cycle as the `sm_*_req` pulse is not possible; the storage manager needs at least one cycle.

## Test plan
- **Single write:** client 1 requests a write of ID 5, 2x2, four words.
  - `sm_write_req` is one pulse at cycle 1 with `sm_matrix_id` = 5.
  - The four `sm_write_data_valid` beats match `cl_wdata[1]`.
  - `cl_done[1]` pulses once after `sm_write_done`.
- **Round-robin:** clients 0, 1 and 2 all hold `cl_req` from reset.
  - Grant order is 0, 1, 2, 0, 1, 2.
  - `cl_grant` is never multi-hot.
- **Ready stall:** `sm_reader_ready` is held low for 10 cycles during ISSUE.
  - The grant stays high with no `sm_read_req`.
  - The pulse comes in the first cycle ready is high and lasts one cycle.
- **Read qualification:** client 2 holds a read grant while client 0 toggles `cl_rdata_req[0]`.
  - `sm_read_data_req` follows only client 2.
  - `cl_rdata_valid[0]` stays 0 and `cl_rdata_valid[2]` mirrors `sm_read_data_valid`.
- **Wrong-op done:** an `sm_read_done` pulse arrives during a write session. The FSM stays in BUSY with no `cl_done`.
- **Reset mid-session:** `rst` is asserted in BUSY with `last` = 1.
  - All outputs are 0 immediately.
  - After release, pending requests 1 and 2 give client 1 first, because `last` resets to NUM_CLIENTS-1 and 0 is not requesting.
